pwm_ramp_ctrl: RTL and testbench

- Multi-channel controller in front of the pwm datapath blocks.
- Generates the shared one_MHz_enable tick from clk.
- Accepts per-channel duty targets over a valid/ready command port.
- Slews each channel's duty_cycle toward its target at a fixed rate; supports emergency stop.

---
 rtl/pwm_ramp_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_ctrl.sv
// Purpose: multi-channel duty-cycle ramp controller with 1 MHz tick generation and emergency stop.
// Latency: accepted command updates target at the accepting edge; duty moves on the next ramp step.
// Backpressure: cmd_ready is low during reset, in STOP, and for one clk after leaving either.
// Optional: define PWM_RAMP_IMMEDIATE_EN to add cmd_immediate (load duty directly, no ramp).
module pwm_ramp_ctrl #(
   parameter int NUM_CH     = 2,
   parameter int CLK_DIV    = 65,
   parameter int RAMP_TICKS = 1000,
   parameter int STEP       = 1,
   parameter int CH_W       = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [CH_W-1:0]       cmd_ch,
   input  logic [6:0]            cmd_duty,
`ifdef PWM_RAMP_IMMEDIATE_EN
   input  logic                  cmd_immediate,
`endif
   input  logic                  estop,
   output logic                  one_MHz_enable,
   output logic [7*NUM_CH-1:0]   duty_cycle,
   output logic [NUM_CH-1:0]     busy,
   output logic                  cmd_err
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int RT_W  = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
   localparam logic [7:0] STEP8 = 8'(STEP);

   typedef enum logic {RUN, STOP} gstate_t;
   typedef enum logic [1:0] {IDLE, UP, DOWN} ch_state_t;

   gstate_t          gstate, gstate_nxt;
   ch_state_t        chs_q   [NUM_CH];
   ch_state_t        chs_nxt [NUM_CH];
   logic [6:0]       duty_q   [NUM_CH];
   logic [6:0]       duty_nxt [NUM_CH];
   logic [6:0]       tgt_q    [NUM_CH];
   logic [6:0]       tgt_nxt  [NUM_CH];
   logic [DIV_W-1:0] div_cnt;
   logic [RT_W-1:0]  ramp_cnt;
   logic             div_wrap;
   logic             step_strobe;
   logic             accept;
   logic             ch_ok;
   logic             over;
   logic [6:0]       clamped;
   logic             err_nxt;

   // Move d toward t by at most STEP; 8-bit math so sums never wrap.
   function automatic logic [6:0] step_toward(input logic [6:0] d, input logic [6:0] t);
      logic [7:0] d8;
      logic [7:0] t8;
      d8 = {1'b0, d};
      t8 = {1'b0, t};
      if (d8 < t8) begin
         step_toward = ((t8 - d8) > STEP8) ? 7'(d8 + STEP8) : t;
      end else if (d8 > t8) begin
         step_toward = ((d8 - t8) > STEP8) ? 7'(d8 - STEP8) : t;
      end else begin
         step_toward = d;
      end
   endfunction

   assign div_wrap    = (div_cnt == DIV_W'(CLK_DIV - 1));
   assign step_strobe = one_MHz_enable && (ramp_cnt == RT_W'(RAMP_TICKS - 1));
   assign accept      = cmd_valid && cmd_ready && !estop;
   assign ch_ok       = (32'(cmd_ch) < NUM_CH);
   assign over        = (cmd_duty > 7'd100);
   assign clamped     = over ? 7'd100 : cmd_duty;

   // Clock divider producing the registered 1 MHz strobe and the free-running ramp timer.
   always_ff @(posedge clk) begin
      if (!reset) begin
         div_cnt        <= '0;
         one_MHz_enable <= 1'b0;
         ramp_cnt       <= '0;
      end else begin
         one_MHz_enable <= div_wrap;
         div_cnt        <= div_wrap ? '0 : div_cnt + 1'b1;
         if (one_MHz_enable) begin
            ramp_cnt <= step_strobe ? '0 : ramp_cnt + 1'b1;
         end
      end
   end

   // Global RUN/STOP next-state; estop is level-sensitive.
   always_comb begin
      gstate_nxt = gstate;
      case (gstate)
         RUN:     if (estop)  gstate_nxt = STOP;
         STOP:    if (!estop) gstate_nxt = RUN;
         default: gstate_nxt = RUN;
      endcase
   end

   // Per-channel next duty/target/state: estop first, then ramp step on old target, then command.
   always_comb begin
      err_nxt = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         duty_nxt[k] = duty_q[k];
         tgt_nxt[k]  = tgt_q[k];
         chs_nxt[k]  = chs_q[k];
      end
      if (estop || gstate == STOP) begin
         for (int k = 0; k < NUM_CH; k++) begin
            duty_nxt[k] = 7'd0;
            tgt_nxt[k]  = 7'd0;
            chs_nxt[k]  = IDLE;
         end
      end else begin
         if (step_strobe) begin
            for (int k = 0; k < NUM_CH; k++) begin
               duty_nxt[k] = step_toward(duty_q[k], tgt_q[k]);
               if (duty_q[k] < tgt_q[k])      chs_nxt[k] = UP;
               else if (duty_q[k] > tgt_q[k]) chs_nxt[k] = DOWN;
               else                           chs_nxt[k] = IDLE;
            end
         end
         if (accept) begin
            err_nxt = !ch_ok || over;
            for (int k = 0; k < NUM_CH; k++) begin
               if (ch_ok && (32'(cmd_ch) == 32'(k))) begin
                  tgt_nxt[k] = clamped;
`ifdef PWM_RAMP_IMMEDIATE_EN
                  if (cmd_immediate) begin
                     duty_nxt[k] = clamped;
                     chs_nxt[k]  = IDLE;
                  end
`endif
               end
            end
         end
      end
   end

   // State, channel and handshake registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         gstate    <= RUN;
         cmd_ready <= 1'b0;
         cmd_err   <= 1'b0;
         busy      <= '0;
         for (int k = 0; k < NUM_CH; k++) begin
            duty_q[k] <= 7'd0;
            tgt_q[k]  <= 7'd0;
            chs_q[k]  <= IDLE;
         end
      end else begin
         gstate    <= gstate_nxt;
         cmd_ready <= (gstate_nxt == RUN);
         cmd_err   <= err_nxt;
         for (int k = 0; k < NUM_CH; k++) begin
            busy[k]   <= (duty_q[k] != tgt_q[k]);
            duty_q[k] <= duty_nxt[k];
            tgt_q[k]  <= tgt_nxt[k];
            chs_q[k]  <= chs_nxt[k];
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_duty
      assign duty_cycle[7*g +: 7] = duty_q[g];
   end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
module tb_pwm_ramp_ctrl;

   localparam int NCH = 2;
   localparam int CD  = 4;
   localparam int RT  = 2;
   localparam int ST  = 5;
   localparam int CW  = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [CW-1:0]     cmd_ch;
   logic [6:0]        cmd_duty;
   logic              estop;
   logic              one_MHz_enable;
   logic [7*NCH-1:0]  duty_cycle;
   logic [NCH-1:0]    busy;
   logic              cmd_err;
   logic              imm;
`ifdef PWM_RAMP_IMMEDIATE_EN
   logic              cmd_immediate;
   assign cmd_immediate = imm;
`endif

   pwm_ramp_ctrl #(
      .NUM_CH(NCH), .CLK_DIV(CD), .RAMP_TICKS(RT), .STEP(ST), .CH_W(CW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_ch(cmd_ch),
      .cmd_duty(cmd_duty),
`ifdef PWM_RAMP_IMMEDIATE_EN
      .cmd_immediate(cmd_immediate),
`endif
      .estop(estop),
      .one_MHz_enable(one_MHz_enable),
      .duty_cycle(duty_cycle),
      .busy(busy),
      .cmd_err(cmd_err)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model state
   int m_duty [NCH];
   int m_tgt  [NCH];
   int m_busy [NCH];
   int m_ready, m_err, m_en, m_run;
   int k_edges;   // rising edges since reset release

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Behavioural model: ramp steps happen every CD*RT clocks after each
   // completed batch of RT one-microsecond ticks.
   task automatic model_edge();
      int  nb [NCH];
      bit  step;
      bit  acc;
      int  nt;
      bit  use_imm;
      use_imm = 1'b0;
`ifdef PWM_RAMP_IMMEDIATE_EN
      use_imm = imm;
`endif
      if (!reset) begin
         for (int c = 0; c < NCH; c++) begin
            m_duty[c] = 0; m_tgt[c] = 0; m_busy[c] = 0;
         end
         m_ready = 0; m_err = 0; m_en = 0; m_run = 1; k_edges = 0;
         return;
      end
      for (int c = 0; c < NCH; c++) nb[c] = (m_duty[c] != m_tgt[c]);
      k_edges++;
      step = (k_edges > 1) && ((k_edges - 1) % CD == 0) && (((k_edges - 1) / CD) % RT == 0);
      m_en = (k_edges % CD == 0);
      acc  = cmd_valid && (m_ready != 0) && !estop;
      if (estop) begin
         m_run = 0; m_ready = 0; m_err = 0;
         for (int c = 0; c < NCH; c++) begin m_duty[c] = 0; m_tgt[c] = 0; end
      end else if (m_run == 0) begin
         m_run = 1; m_ready = 1; m_err = 0;
      end else begin
         m_ready = 1; m_err = 0;
         if (step) begin
            for (int c = 0; c < NCH; c++) begin
               if (m_duty[c] < m_tgt[c])
                  m_duty[c] += (m_tgt[c] - m_duty[c] < ST) ? m_tgt[c] - m_duty[c] : ST;
               else if (m_duty[c] > m_tgt[c])
                  m_duty[c] -= (m_duty[c] - m_tgt[c] < ST) ? m_duty[c] - m_tgt[c] : ST;
            end
         end
         if (acc) begin
            if (int'(cmd_ch) >= NCH) begin
               m_err = 1;
            end else begin
               nt = (cmd_duty > 100) ? 100 : int'(cmd_duty);
               m_err = (cmd_duty > 100);
               m_tgt[cmd_ch] = nt;
               if (use_imm) m_duty[cmd_ch] = nt;
            end
         end
      end
      for (int c = 0; c < NCH; c++) m_busy[c] = nb[c];
   endtask

   task automatic compare_all();
      logic [6:0] d;
      for (int c = 0; c < NCH; c++) begin
         d = duty_cycle[7*c +: 7];
         chk($sformatf("duty%0d", c), 32'(d), 32'(m_duty[c]));
         chk($sformatf("busy%0d", c), 32'(busy[c]), 32'(m_busy[c]));
      end
      chk("cmd_ready", 32'(cmd_ready), 32'(m_ready));
      chk("one_MHz_enable", 32'(one_MHz_enable), 32'(m_en));
      chk("cmd_err", 32'(cmd_err), 32'(m_err));
   endtask

   task automatic cyc(input bit r, input bit v, input int ch, input int dty,
                      input bit e, input bit im);
      reset     = r;
      cmd_valid = v;
      cmd_ch    = CW'(ch);
      cmd_duty  = 7'(dty);
      estop     = e;
      imm       = im;
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0);
   endtask

   int est_left;

   initial begin
      // Power-up reset, some activity, then reset mid-ramp for 3 clks
      for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0, 0, 0);
      idle(3);
      cyc(1, 1, 0, 90, 0, 0);
      cyc(1, 1, 1, 70, 0, 0);
      idle(20);
      for (int i = 0; i < 3; i++) cyc(0, 1, 0, 50, 0, 0);
      idle(16);

      // ch0 -> 23, ramp 5,10,15,20,23
      cyc(1, 1, 0, 23, 0, 0);
      idle(50);
      // ch1 -> 127 clamps to 100
      cyc(1, 1, 1, 127, 0, 0);
      idle(170);
      // invalid channel
      cyc(1, 1, 3, 40, 0, 0);
      idle(3);
      // ch0 up then reversed mid-ramp
      cyc(1, 1, 0, 60, 0, 0);
      idle(30);
      cyc(1, 1, 0, 5, 0, 0);
      idle(40);
      // back-to-back, last write wins
      cyc(1, 1, 0, 40, 0, 0);
      cyc(1, 1, 0, 41, 0, 0);
      cyc(1, 1, 1, 60, 0, 0);
      idle(120);
      // estop with commands offered
      for (int i = 0; i < 4; i++) cyc(1, 1, i % 2, 90, 1, 1);
      cyc(1, 1, 0, 90, 0, 0);
      idle(10);
      // immediate load (only effective when the feature is built in)
      cyc(1, 1, 0, 80, 0, 1);
      idle(10);

      // Randomized traffic
      est_left = 0;
      for (int i = 0; i < 3000; i++) begin
         bit r, v, e, im;
         r  = ($urandom_range(0, 599) != 0);
         v  = ($urandom_range(0, 5) == 0);
         im = ($urandom_range(0, 3) == 0);
         if (est_left > 0) est_left--;
         else if ($urandom_range(0, 299) == 0) est_left = $urandom_range(1, 6);
         e = (est_left > 0);
         cyc(r, v, $urandom_range(0, 3), $urandom_range(0, 127), e, im);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
